// File: rtl/irq_gateway.sv
// Interrupt gateway: synchronises raw lines, applies edge/level trigger and enable
// masking, and tracks pending/in-service per source. Optional macro: IRQ_EDGE_CNT_EN.
module irq_gateway #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_CNT_W  = 2
) (
    input  logic               pclk,
    input  logic               preset_n,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [NUM_IRQ-1:0] trig_mode,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               claim_valid,
    input  logic [3:0]         claim_id,
    input  logic               complete_valid,
    input  logic [3:0]         complete_id,
    output logic [NUM_IRQ-1:0] irq_req,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service
);
    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_SERV} state_t;

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
    logic [NUM_IRQ-1:0]                  r_hist;
    logic [NUM_IRQ-1:0]                  r_rise;

    // The rise pulse is registered so edge and level sources share one decision point.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_sync <= '0;
            r_hist <= '0;
            r_rise <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], irq_src};
            r_hist <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_hist;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_src
            state_t r_state;
            state_t w_state_next;
            logic   r_mode;
            logic   r_req;
            logic   w_mode;
            logic   w_claim;
            logic   w_done;
            logic   w_erise;
            logic   w_cnt_avail;

            assign w_claim = claim_valid && (claim_id == 4'(gi + 1));
            assign w_done  = complete_valid && (complete_id == 4'(gi + 1));
            assign w_mode  = (r_state == ST_IDLE) ? trig_mode[gi] : r_mode;
            assign w_erise = w_mode && r_rise[gi] && irq_en[gi];

`ifdef IRQ_EDGE_CNT_EN
            localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;
            logic [EDGE_CNT_W-1:0] r_cnt;
            logic [EDGE_CNT_W-1:0] w_cnt_next;

            assign w_cnt_avail = (r_cnt != '0);

            // An edge landing on the completing cycle replaces the decrement (net zero).
            always_comb begin
                w_cnt_next = r_cnt;
                if (r_state == ST_SERV && w_done) begin
                    if (!w_erise && w_cnt_avail)
                        w_cnt_next = r_cnt - EDGE_CNT_W'(1);
                end else if (r_state != ST_IDLE && w_erise && r_cnt != CNT_MAX) begin
                    w_cnt_next = r_cnt + EDGE_CNT_W'(1);
                end
            end

            always_ff @(posedge pclk or negedge preset_n) begin
                if (!preset_n)
                    r_cnt <= '0;
                else
                    r_cnt <= w_cnt_next;
            end
`else
            assign w_cnt_avail = 1'b0;
`endif

            always_comb begin
                w_state_next = r_state;
                case (r_state)
                    ST_IDLE: begin
                        if (irq_en[gi] && (trig_mode[gi] ? r_rise[gi] : r_hist[gi]))
                            w_state_next = ST_PEND;
                    end
                    ST_PEND: begin
                        if (w_claim)
                            w_state_next = ST_SERV;
                        else if (!w_mode && !r_hist[gi])
                            w_state_next = ST_IDLE;
                    end
                    ST_SERV: begin
                        if (w_done)
                            w_state_next = (w_erise || w_cnt_avail) ? ST_PEND : ST_IDLE;
                    end
                    default: w_state_next = ST_IDLE;
                endcase
            end

            always_ff @(posedge pclk or negedge preset_n) begin
                if (!preset_n) begin
                    r_state <= ST_IDLE;
                    r_mode  <= 1'b0;
                    r_req   <= 1'b0;
                end else begin
                    r_state <= w_state_next;
                    if (r_state == ST_IDLE)
                        r_mode <= trig_mode[gi];
                    r_req <= (w_state_next == ST_PEND) && irq_en[gi];
                end
            end

            assign irq_req[gi]    = r_req;
            assign pending[gi]    = (r_state == ST_PEND);
            assign in_service[gi] = (r_state == ST_SERV);
        end
    endgenerate
endmodule

// File: tb/tb_irq_gateway.sv
// Self-checking bench for irq_gateway: directed scenarios plus random traffic, all
// compared every cycle against a delay-line/lifecycle reference model.
module tb_irq_gateway;
    localparam int N       = 8;
    localparam int CNT_MAX = 3;

    logic         pclk = 1'b0;
    logic         preset_n = 1'b0;
    logic [N-1:0] irq_src, trig_mode, irq_en;
    logic         claim_valid, complete_valid;
    logic [3:0]   claim_id, complete_id;
    logic [N-1:0] irq_req, pending, in_service;

    always #5 pclk = ~pclk;

    irq_gateway #(.NUM_IRQ(N), .SYNC_STAGES(2), .EDGE_CNT_W(2)) dut (
        .pclk(pclk), .preset_n(preset_n), .irq_src(irq_src), .trig_mode(trig_mode),
        .irq_en(irq_en), .claim_valid(claim_valid), .claim_id(claim_id),
        .complete_valid(complete_valid), .complete_id(complete_id),
        .irq_req(irq_req), .pending(pending), .in_service(in_service)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model: 0 = idle, 1 = pending, 2 = in service. h1..h4 hold irq_src as sampled
    // at the last four edges; the gateway acts on the line three edges late.
    int           m_st [N];
    int           m_cnt[N];
    bit           m_mode[N];
    logic [N-1:0] m_req, h1, h2, h3, h4;

    function automatic logic [N-1:0] st_vec(int s);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = (m_st[i] == s);
        return v;
    endfunction

    task automatic check(string tag, logic [N-1:0] got, logic [N-1:0] exp);
        n_chk++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_mode[i] = 1'b0;
        end
        m_req = '0; h1 = '0; h2 = '0; h3 = '0; h4 = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] lvl, rise;
        lvl  = h3;
        rise = h3 & ~h4;
        for (int n = 0; n < N; n++) begin
            bit en, tm, cl, dn, mode, erise;
            int ns;
            en    = irq_en[n];
            tm    = trig_mode[n];
            cl    = claim_valid && (claim_id == 4'(n + 1));
            dn    = complete_valid && (complete_id == 4'(n + 1));
            mode  = (m_st[n] == 0) ? tm : m_mode[n];
            erise = mode && rise[n] && en;
            ns    = m_st[n];
            if (m_st[n] == 0) begin
                m_mode[n] = tm;
                if (en && (tm ? rise[n] : lvl[n])) ns = 1;
            end else if (m_st[n] == 1) begin
                if (cl) ns = 2;
                else if (!mode && !lvl[n]) ns = 0;
`ifdef IRQ_EDGE_CNT_EN
                if (erise && m_cnt[n] < CNT_MAX) m_cnt[n]++;
`endif
            end else begin
                if (dn) begin
                    if (erise) ns = 1;
                    else if (m_cnt[n] > 0) begin
                        ns = 1;
                        m_cnt[n]--;
                    end else ns = 0;
                end else begin
`ifdef IRQ_EDGE_CNT_EN
                    if (erise && m_cnt[n] < CNT_MAX) m_cnt[n]++;
`endif
                end
            end
            m_st[n]  = ns;
            m_req[n] = (ns == 1) && en;
        end
        h4 = h3; h3 = h2; h2 = h1; h1 = irq_src;
    endtask

    task automatic tick();
        @(posedge pclk);
        model_step();
        #1;
        check("pending", pending, st_vec(1));
        check("in_service", in_service, st_vec(2));
        check("irq_req", irq_req, m_req);
    endtask

    task automatic pulse(int n);
        irq_src[n] = 1'b1;
        tick();
        irq_src[n] = 1'b0;
    endtask

    task automatic claim(int id);
        claim_valid = 1'b1; claim_id = 4'(id);
        tick();
        claim_valid = 1'b0; claim_id = '0;
    endtask

    task automatic complete(int id);
        complete_valid = 1'b1; complete_id = 4'(id);
        tick();
        complete_valid = 1'b0; complete_id = '0;
    endtask

    task automatic async_reset(string tag);
        #2 preset_n = 1'b0;
        #1;
        check({tag, "_req"}, irq_req, '0);
        check({tag, "_pend"}, pending, '0);
        check({tag, "_serv"}, in_service, '0);
        model_reset();
        #1 preset_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] exp_p;
        int           bad_ids[4];
        irq_src = '0; trig_mode = '0; irq_en = '1;
        claim_valid = 1'b0; claim_id = '0; complete_valid = 1'b0; complete_id = '0;
        model_reset();
        #12;
        check("rst_req", irq_req, '0);
        check("rst_pend", pending, '0);
        check("rst_serv", in_service, '0);
        preset_n = 1'b1;

        // 1: edge source 3, latency, claim, complete
        trig_mode = 8'h08;
        pulse(3);
        tick(); tick();
        check("t1_req_early", irq_req, 8'h00);
        tick();
        check("t1_req", irq_req, 8'h08);
        claim(4);
        check("t1_claim_pend", pending, 8'h00);
        check("t1_claim_serv", in_service, 8'h08);
        check("t1_claim_req", irq_req, 8'h00);
        complete(4);
        check("t1_done_serv", in_service, 8'h00);
        check("t1_done_pend", pending, 8'h00);

        // 2: level source 0 re-pends after complete, withdraws on drop
        irq_src[0] = 1'b1;
        tick(); tick(); tick();
        check("t2_pend_early", pending, 8'h00);
        tick();
        check("t2_pend", pending, 8'h01);
        claim(1);
        check("t2_serv", in_service, 8'h01);
        complete(1);
        check("t2_idle", pending | in_service, 8'h00);
        tick();
        check("t2_repend", pending, 8'h01);
        irq_src[0] = 1'b0;
        tick(); tick(); tick();
        check("t2_hold", pending, 8'h01);
        tick();
        check("t2_withdraw_p", pending, 8'h00);
        check("t2_withdraw_r", irq_req, 8'h00);

        // 3: enable masking
        trig_mode = 8'h28;
        irq_en = 8'hDF;
        pulse(5);
        repeat (4) tick();
        check("t3_drop_p", pending, 8'h00);
        check("t3_drop_r", irq_req, 8'h00);
        irq_en = 8'hFF;
        pulse(5);
        repeat (3) tick();
        check("t3_pend", pending, 8'h20);
        irq_en = 8'hDF;
        tick();
        check("t3_mask_p", pending, 8'h20);
        check("t3_mask_r", irq_req, 8'h00);
        irq_en = 8'hFF;
        tick();
        check("t3_unmask_r", irq_req, 8'h20);
        claim(6);
        complete(6);

        // 4: ignored claims and completes
        bad_ids = '{0, 9, 2, 15};
        foreach (bad_ids[i]) begin
            claim(bad_ids[i]);
            check("t4_claim", pending | in_service | irq_req, 8'h00);
        end
        complete(7);
        check("t4_complete", pending | in_service | irq_req, 8'h00);

        // 5: simultaneous claim/complete on different ids, then async reset
        trig_mode = 8'h2E;
        pulse(2);
        repeat (3) tick();
        claim(3);
        check("t5_serv2", in_service, 8'h04);
        pulse(1);
        repeat (3) tick();
        check("t5_pend1", pending, 8'h02);
        claim_valid = 1'b1; claim_id = 4'd2;
        complete_valid = 1'b1; complete_id = 4'd3;
        tick();
        claim_valid = 1'b0; complete_valid = 1'b0;
        check("t5_swap_serv", in_service, 8'h02);
        check("t5_swap_pend", pending, 8'h00);
        async_reset("t5_areset");

        // 6: queued edges on source 7
        trig_mode = 8'h80;
        pulse(7);
        repeat (3) tick();
        claim(8);
        check("t6_serv", in_service, 8'h80);
        repeat (5) begin
            pulse(7);
            tick();
        end
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            complete(8);
`ifdef IRQ_EDGE_CNT_EN
            exp_p = (i < 3) ? 8'h80 : 8'h00;
`else
            exp_p = 8'h00;
`endif
            check("t6_repend", pending, exp_p);
            if (pending[7]) claim(8);
        end
        check("t6_final", in_service, 8'h00);

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            irq_src ^= N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 39) == 0) trig_mode = N'($urandom);
            if ($urandom_range(0, 19) == 0) irq_en[$urandom_range(0, N - 1)] ^= 1'b1;
            claim_valid    = ($urandom_range(0, 1) == 1);
            claim_id       = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                         : 4'($urandom_range(1, 8));
            complete_valid = ($urandom_range(0, 2) == 0);
            complete_id    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                         : 4'($urandom_range(1, 8));
            tick();
            if ($urandom_range(0, 299) == 0) async_reset("rnd_areset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
